// File: rtl/ll_walker.sv
// Linked-list pointer walker: a runtime-writable next-pointer table, a queue of list
// heads, and a valid/ready output that emits one list element per beat with a last flag.
module ll_walker #(
  parameter int N           = 16,
  parameter int W           = $clog2(N),
  parameter int START_DEPTH = 4,
  parameter int MAX_HOPS    = N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_next,
  input  logic         start_vld,
  input  logic [W-1:0] start_ptr,
  output logic         start_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_ptr,
  output logic         out_last,
  output logic         out_err,
  output logic         busy
);

  localparam int AW = $clog2(START_DEPTH);
  localparam int CW = $clog2(START_DEPTH + 1);
  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam logic [HW-1:0] HOPS_LIM  = HW'(MAX_HOPS);
  localparam logic [CW-1:0] FIFO_FULL = CW'(START_DEPTH);

  typedef enum logic {IDLE, WALK} state_t;

  state_t          state, state_d;
  logic [W-1:0]    tbl [N];
  logic [W-1:0]    fifo_mem [START_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    head;
  logic            empty, full, push, pop;
  logic            load, advance;
  logic [W-1:0]    cur_p0;
  logic [HW-1:0]   hops;
  logic [W-1:0]    hold_nxt_p1;
  logic            hold_vld_p1;
  logic [W-1:0]    nxt;
  logic            at_lim;
  logic            stall;

  // Next-pointer table; entry 0 is the null terminator and never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl[i] <= '0;
    end else if (cfg_we && (cfg_addr != '0)) begin
      tbl[cfg_addr] <= cfg_next;
    end
  end

  assign empty     = (cnt == '0);
  assign full      = (cnt == FIFO_FULL);
  assign start_rdy = ~full;
  assign push      = start_vld & start_rdy;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = ~empty | (state == WALK);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= start_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Once a beat stalls, its successor is frozen so a table write cannot
  // change out_last/out_err while the beat is still being offered.
  always_comb begin
    nxt    = hold_vld_p1 ? hold_nxt_p1 : tbl[cur_p0];
    at_lim = (hops == HOPS_LIM);
    stall  = (state == WALK) & ~out_rdy;
  end

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    out_vld  = 1'b0;
    out_ptr  = '0;
    out_last = 1'b0;
    out_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head != '0) begin
            load    = 1'b1;
            state_d = WALK;
          end
        end
      end
      WALK: begin
        out_vld  = 1'b1;
        out_ptr  = cur_p0;
        out_last = (nxt == '0) | at_lim;
        out_err  = (nxt != '0) & at_lim;
        if (out_rdy) begin
          if (!out_last) begin
            advance = 1'b1;
          end else if (!empty) begin
            // Chain straight into the next queued list without a bubble.
            pop = 1'b1;
            if (head != '0) load = 1'b1;
            else            state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hops        <= '0;
      hold_vld_p1 <= 1'b0;
    end else begin
      state       <= state_d;
      hold_vld_p1 <= stall;
      if (load)         hops <= HW'(1);
      else if (advance) hops <= hops + HW'(1);
    end
  end

  // Walk pointer and frozen successor: data only, qualified by state/hold_vld_p1.
  always_ff @(posedge clk) begin
    if (load)         cur_p0 <= head;
    else if (advance) cur_p0 <= nxt;
    if (stall && !hold_vld_p1) hold_nxt_p1 <= tbl[cur_p0];
  end

endmodule

// File: tb/tb_ll_walker.sv
// Scoreboard bench for ll_walker: expected beats are queued as stimulus is driven
// and popped as the walker emits them.
module tb_ll_walker;
  localparam int N  = 16;
  localparam int W  = 4;
  localparam int SD = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [W-1:0] cfg_addr, cfg_next;
  logic         start_vld;
  logic [W-1:0] start_ptr;
  logic         start_rdy;
  logic         out_vld, out_rdy;
  logic [W-1:0] out_ptr;
  logic         out_last, out_err, busy;

  typedef struct packed {
    logic [W-1:0] ptr;
    logic         last;
    logic         err;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  ll_walker #(.N(N), .W(W), .START_DEPTH(SD), .MAX_HOPS(MH)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .start_vld(start_vld), .start_ptr(start_ptr), .start_rdy(start_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_ptr(out_ptr),
    .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  function automatic beat_t mk(input int p, input bit l, input bit e);
    beat_t b;
    b.ptr = W'(p); b.last = l; b.err = e;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int a, input int n);
    cfg_we = 1'b1; cfg_addr = W'(a); cfg_next = W'(n);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic push_start(input int p);
    int t = 0;
    start_vld = 1'b1; start_ptr = W'(p);
    while (!start_rdy && t < 50) begin tick(); t++; end
    n_checks++;
    if (start_rdy !== 1'b1) begin
      $display("FAIL push_timeout ptr=%0d start_rdy=%b required 1", p, start_rdy);
      n_errors++;
    end
    tick();
    start_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_vld, out_ptr, out_last, out_err, start_rdy, busy} !== {1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_outputs vld=%b ptr=%0d last=%b err=%b start_rdy=%b busy=%b required 0,0,0,0,1,0",
               out_vld, out_ptr, out_last, out_err, start_rdy, busy);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_single_list();
    beat_t e;
    cfg_write(1, 5); cfg_write(5, 3); cfg_write(3, 10); cfg_write(10, 0);
    exp_q = {};
    exp_q.push_back(mk(1, 0, 0)); exp_q.push_back(mk(5, 0, 0));
    exp_q.push_back(mk(3, 0, 0)); exp_q.push_back(mk(10, 1, 0));
    out_rdy = 1'b1;
    start_vld = 1'b1; start_ptr = 4'd1;
    tick();
    start_vld = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b0) begin
      $display("FAIL latency_idle out_vld=%b required 0", out_vld);
      n_errors++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, e.ptr, e.last, e.err}) begin
        $display("FAIL single_beat%0d got vld=%b ptr=%0d last=%b err=%b required 1,%0d,%b,%b",
                 i, out_vld, out_ptr, out_last, out_err, e.ptr, e.last, e.err);
        n_errors++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      $display("FAIL single_end vld=%b busy=%b required 0,0", out_vld, busy);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    beat_t e;
    cfg_write(7, 15); cfg_write(15, 8); cfg_write(8, 0);
    cfg_write(6, 0);  cfg_write(2, 4);  cfg_write(4, 0);
    exp_q = {};
    exp_q.push_back(mk(7, 0, 0)); exp_q.push_back(mk(15, 0, 0)); exp_q.push_back(mk(8, 1, 0));
    exp_q.push_back(mk(6, 1, 0)); exp_q.push_back(mk(2, 0, 0));  exp_q.push_back(mk(4, 1, 0));
    out_rdy = 1'b0;
    push_start(7); push_start(6); push_start(2);
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, e.ptr, e.last, e.err}) begin
        $display("FAIL b2b_beat%0d got vld=%b ptr=%0d last=%b err=%b required 1,%0d,%b,%b",
                 i, out_vld, out_ptr, out_last, out_err, e.ptr, e.last, e.err);
        n_errors++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      $display("FAIL b2b_end vld=%b busy=%b required 0,0", out_vld, busy);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    beat_t e;
    logic [W+2:0] held;
    bit   held_valid = 0;
    logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_q = {};
    exp_q.push_back(mk(1, 0, 0)); exp_q.push_back(mk(5, 0, 0));
    exp_q.push_back(mk(3, 0, 0)); exp_q.push_back(mk(10, 1, 0));
    out_rdy = 1'b1;
    start_vld = 1'b1; start_ptr = 4'd1;
    tick();
    start_vld = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      out_rdy  = pat[c];
      cfg_we   = (c == 5);
      cfg_addr = 4'd10; cfg_next = 4'd7;
      @(negedge clk);
      if (held_valid) begin
        n_checks++;
        if ({out_vld, out_ptr, out_last, out_err} !== held) begin
          $display("FAIL stall_hold cycle%0d got %b required %b", c,
                   {out_vld, out_ptr, out_last, out_err}, held);
          n_errors++;
        end
      end
      if (out_rdy) begin
        held_valid = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL bp_extra cycle%0d got ptr=%0d required no beat", c, out_ptr);
          n_errors++;
        end else begin
          e = exp_q.pop_front();
          if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, e.ptr, e.last, e.err}) begin
            $display("FAIL bp_beat cycle%0d got vld=%b ptr=%0d last=%b err=%b required 1,%0d,%b,%b",
                     c, out_vld, out_ptr, out_last, out_err, e.ptr, e.last, e.err);
            n_errors++;
          end
        end
      end else begin
        held = {out_vld, out_ptr, out_last, out_err};
        held_valid = 1;
      end
      tick();
    end
    cfg_we = 1'b0;
    cfg_write(10, 0);
    @(negedge clk);
    n_checks++;
    if ({out_vld, busy, exp_q.size() == 0} !== 3'b001) begin
      $display("FAIL bp_end vld=%b busy=%b pending=%0d required 0,0,0", out_vld, busy, exp_q.size());
      n_errors++;
    end
    tick();
  endtask

  task automatic test_cycle();
    beat_t e;
    cfg_write(9, 14); cfg_write(14, 9);
    exp_q = {};
    exp_q.push_back(mk(9, 0, 0)); exp_q.push_back(mk(14, 0, 0));
    exp_q.push_back(mk(9, 0, 0)); exp_q.push_back(mk(14, 1, 1));
    exp_q.push_back(mk(6, 1, 0));
    out_rdy = 1'b0;
    push_start(9); push_start(6);
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, e.ptr, e.last, e.err}) begin
        $display("FAIL cycle_beat%0d got vld=%b ptr=%0d last=%b err=%b required 1,%0d,%b,%b",
                 i, out_vld, out_ptr, out_last, out_err, e.ptr, e.last, e.err);
        n_errors++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      $display("FAIL cycle_end vld=%b busy=%b required 0,0", out_vld, busy);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_fifo_full();
    beat_t e;
    bit accepted = 0;
    int beats = 0;
    exp_q = {};
    exp_q.push_back(mk(1, 0, 0)); exp_q.push_back(mk(5, 0, 0));
    exp_q.push_back(mk(3, 0, 0)); exp_q.push_back(mk(10, 1, 0));
    exp_q.push_back(mk(6, 1, 0)); exp_q.push_back(mk(2, 0, 0));
    exp_q.push_back(mk(4, 1, 0)); exp_q.push_back(mk(8, 1, 0));
    exp_q.push_back(mk(4, 1, 0));
    out_rdy = 1'b0;
    push_start(1);
    tick();
    push_start(0); push_start(6); push_start(2); push_start(8);
    start_vld = 1'b1; start_ptr = 4'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({start_rdy, busy} !== 2'b01) begin
        $display("FAIL fifo_full%0d start_rdy=%b busy=%b required 0,1", i, start_rdy, busy);
        n_errors++;
      end
      tick();
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 40 && !(accepted && exp_q.size() == 0); c++) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL full_extra got ptr=%0d required no beat", out_ptr);
          n_errors++;
        end else begin
          e = exp_q.pop_front();
          if ({out_ptr, out_last, out_err} !== {e.ptr, e.last, e.err}) begin
            $display("FAIL full_beat%0d got ptr=%0d last=%b err=%b required %0d,%b,%b",
                     beats, out_ptr, out_last, out_err, e.ptr, e.last, e.err);
            n_errors++;
          end
        end
        beats++;
      end
      if (!accepted && start_rdy) begin
        n_checks++;
        if (beats !== 4) begin
          $display("FAIL fifth_push_after_pop beats_before_rdy=%0d required 4", beats);
          n_errors++;
        end
        accepted = 1;
      end
      tick();
      if (accepted) start_vld = 1'b0;
    end
    start_vld = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({accepted, exp_q.size() == 0, out_vld, busy} !== 4'b1100) begin
      $display("FAIL full_end accepted=%b pending=%0d vld=%b busy=%b required 1,0,0,0",
               accepted, exp_q.size(), out_vld, busy);
      n_errors++;
    end
    tick();
  endtask

  task automatic test_reset_mid_walk();
    out_rdy = 1'b0;
    push_start(1); push_start(6); push_start(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_vld, out_ptr, out_last, out_err, start_rdy, busy} !== {1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL midreset_outputs vld=%b ptr=%0d last=%b err=%b start_rdy=%b busy=%b required 0,0,0,0,1,0",
               out_vld, out_ptr, out_last, out_err, start_rdy, busy);
      n_errors++;
    end
    tick();
    out_rdy = 1'b1;
    push_start(1);
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b0) begin
      $display("FAIL midreset_latency out_vld=%b required 0", out_vld);
      n_errors++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      $display("FAIL midreset_table_cleared got vld=%b ptr=%0d last=%b err=%b required 1,1,1,0",
               out_vld, out_ptr, out_last, out_err);
      n_errors++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      $display("FAIL midreset_end vld=%b busy=%b required 0,0", out_vld, busy);
      n_errors++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0;
    start_vld = 1'b0; start_ptr = '0; out_rdy = 1'b0;
    test_reset();
    test_single_list();
    test_back_to_back();
    test_backpressure();
    test_cycle();
    test_fifo_full();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
